// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: frame check, E0/F0 prefix FSM, key-event FIFO, error/overflow status.
// Latency: frame_valid in cycle N -> evt_valid in cycle N+1 (first-word-fall-through queue).
// Backpressure: evt_ready stalls the queue head; a push into a full queue with no pop is dropped and sets ovf.
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [10:0] frame,
    input  logic        evt_ready,
    input  logic        clr_err,
    output logic        evt_valid,
    output logic [7:0]  evt_code,
    output logic        evt_ext,
    output logic        evt_break,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic        ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       d;
    logic             frame_ok, is_e0, is_f0, tmo_hit;
    logic             push, err_now;
    evt_t             push_evt;

    assign d        = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    assign is_e0    = (d == 8'hE0);
    assign is_f0    = (d == 8'hF0);
    // A frame arriving on the last count wins over the timeout.
    assign tmo_hit  = (state != S_IDLE) && !frame_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_valid) begin
            if (!frame_ok) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  state_nxt = is_e0 ? S_E0 : (is_f0 ? S_F0 : S_IDLE);
                    S_E0:    state_nxt = is_f0 ? S_E0F0 : (is_e0 ? S_E0 : S_IDLE);
                    S_F0:    state_nxt = is_f0 ? S_F0 : (is_e0 ? S_E0 : S_IDLE);
                    default: state_nxt = S_IDLE;
                endcase
            end
        end else if (tmo_hit) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        err_now  = frame_valid & ~frame_ok;
        if (frame_valid && frame_ok) begin
            case (state)
                S_IDLE: if (!is_e0 && !is_f0) begin
                    push     = 1'b1;
                    push_evt = '{code: d, ext: 1'b0, brk: 1'b0};
                end
                S_E0: if (!is_e0 && !is_f0) begin
                    push     = 1'b1;
                    push_evt = '{code: d, ext: 1'b1, brk: 1'b0};
                end
                S_F0: begin
                    if (is_e0) begin
                        err_now = 1'b1;
                    end else if (!is_f0) begin
                        push     = 1'b1;
                        push_evt = '{code: d, ext: 1'b0, brk: 1'b1};
                    end
                end
                default: begin
                    if (is_e0 || is_f0) begin
                        err_now = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{code: d, ext: 1'b1, brk: 1'b1};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (frame_valid || state == S_IDLE || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Event queue: pointers carry one extra wrap bit to tell full from empty.
    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             full, pop, wr_en, drop;
    evt_t             head;

    assign evt_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop       = evt_valid & evt_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_evt;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Clear takes effect before a same-cycle error is counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
            ovf       <= 1'b0;
        end else begin
            err_pulse <= err_now;
            if (clr_err)
                err_count <= {7'd0, err_now};
            else if (err_now && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
            if (drop)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
        end
    end

endmodule
